// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, the NOP
// instruction word and the per-cycle control priority order.
package pipe_pkg;

    // FSM state encoding, also exported on state_o for debug
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1,
        DWAIT  = 2'd2,
        HALT   = 2'd3
    } state_t;

    // Instruction word loaded into IF/ID when it is flushed
    localparam logic [15:0] NOP_INST = 16'h0800;

    // Control causes, listed in priority order: a lower value wins
    typedef enum logic [2:0] {
        CAUSE_HALTED   = 3'd0,
        CAUSE_HALT_MEM = 3'd1,
        CAUSE_DMEM     = 3'd2,
        CAUSE_BRANCH   = 3'd3,
        CAUSE_SHADOW   = 3'd4,
        CAUSE_HAZARD   = 3'd5,
        CAUSE_IMEM     = 3'd6,
        CAUSE_NONE     = 3'd7
    } cause_t;

    // Picks the single cause that governs this cycle's controls
    function automatic cause_t select_cause(
        input state_t st,
        input logic   halt_mem,
        input logic   dmem_stall,
        input logic   br_taken,
        input logic   shadow_pending,
        input logic   hazard_n,
        input logic   imem_stall
    );
        if (st == HALT)                   return CAUSE_HALTED;
        if (halt_mem && !dmem_stall)      return CAUSE_HALT_MEM;
        if (dmem_stall)                   return CAUSE_DMEM;
        if (br_taken)                     return CAUSE_BRANCH;
        if (shadow_pending)               return CAUSE_SHADOW;
        if (!hazard_n)                    return CAUSE_HAZARD;
        if (imem_stall)                   return CAUSE_IMEM;
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count enabled cycles, stop at all-ones, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns hazard, redirect, memory
// busy and HALT into per-stage enables and bubble/flush controls.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_SHADOW = 1,
    parameter int MAX_DWAIT = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_n,
    input  logic             br_taken_ex,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             dwait_err,
    output logic [1:0]       state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_haz_cnt,
    output logic [CNT_W-1:0] stall_dmem_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int DW = (MAX_DWAIT < 2) ? 2 : $clog2(MAX_DWAIT + 1);
    localparam logic [DW-1:0] DWAIT_LAST  = DW'(MAX_DWAIT - 1);
    localparam logic [1:0]    SHADOW_LOAD = 2'(BR_SHADOW - 1);

    state_t        state;
    cause_t        cause;
    logic [1:0]    shadow_cnt;
    logic [DW-1:0] dwait_cnt;
    logic          dwait_timeout;

    assign state_o = state;

    // Decide which source owns this cycle and derive the stage controls
    always_comb begin
        cause = select_cause(state, halt_mem, dmem_stall, br_taken_ex,
                             shadow_cnt != 2'd0, hazard_n, imem_stall);
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        memwb_bubble = 1'b0;
        case (cause)
            CAUSE_HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            CAUSE_HALT_MEM: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
            end
            CAUSE_DMEM: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
            CAUSE_BRANCH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            CAUSE_SHADOW: begin
                ifid_flush = 1'b1;
            end
            CAUSE_HAZARD: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
            CAUSE_IMEM: begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dwait_timeout = (MAX_DWAIT != 0) && (cause == CAUSE_DMEM) &&
                           (dwait_cnt == DWAIT_LAST);

    // Consecutive data-memory busy cycles; cleared as soon as busy drops
    pipe_sat_cnt #(.W(DW)) u_dwait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cause == CAUSE_DMEM),
        .clr   (!dmem_stall),
        .cnt   (dwait_cnt)
    );

    // Sequencer FSM: redirect shadow, memory wait, halt and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            shadow_cnt <= 2'd0;
            halted     <= 1'b0;
            dwait_err  <= 1'b0;
        end else begin
            case (cause)
                CAUSE_HALTED: begin
                end
                CAUSE_HALT_MEM: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                CAUSE_DMEM: begin
                    if (dwait_timeout) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        dwait_err <= 1'b1;
                    end else begin
                        state <= DWAIT;
                    end
                end
                CAUSE_BRANCH: begin
                    shadow_cnt <= SHADOW_LOAD;
                    state      <= (BR_SHADOW > 1) ? SHADOW : RUN;
                end
                CAUSE_SHADOW: begin
                    shadow_cnt <= shadow_cnt - 2'd1;
                    state      <= (shadow_cnt > 2'd1) ? SHADOW : RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Hazard stall cycles
    pipe_sat_cnt #(.W(CNT_W)) u_haz_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cause == CAUSE_HAZARD),
        .clr   (1'b0),
        .cnt   (stall_haz_cnt)
    );

    // Data-memory stall cycles
    pipe_sat_cnt #(.W(CNT_W)) u_dmem_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cause == CAUSE_DMEM),
        .clr   (1'b0),
        .cnt   (stall_dmem_cnt)
    );

    // IF/ID flush cycles
    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_flush && (state != HALT)),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with BR_SHADOW=2, MAX_DWAIT=4, CNT_W=4.
// Performance counter checks are compiled when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

    localparam int BR_SHADOW = 2;
    localparam int MAX_DWAIT = 4;
    localparam int CNT_W     = 4;

    // Expected control bus {pc_en, ifid_en, ifid_flush, idex_en,
    //                       idex_bubble, exmem_en, memwb_en, memwb_bubble}
    localparam logic [7:0] C_NORM   = 8'b1101_0110;
    localparam logic [7:0] C_HAZ    = 8'b0001_1110;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_SHADOW = 8'b1111_0110;
    localparam logic [7:0] C_IMEM   = 8'b0111_0110;
    localparam logic [7:0] C_DMEM   = 8'b0000_0011;
    localparam logic [7:0] C_HALTM  = 8'b0000_0010;
    localparam logic [7:0] C_OFF    = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hazard_n = 1'b1;
    logic br_taken_ex = 1'b0;
    logic imem_stall = 1'b0;
    logic dmem_stall = 1'b0;
    logic halt_mem = 1'b0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic exmem_en, memwb_en, memwb_bubble, halted, dwait_err;
    logic [1:0] state_o;
    logic [7:0] ctl;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_haz_cnt, stall_dmem_cnt, flush_cnt;
`endif

    int vectors_applied = 0;
    int miscompares = 0;

    typedef struct {
        logic       hazard_n;
        logic       br;
        logic       imem;
        logic       dmem;
        logic       halt;
        logic [7:0] ctl;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[22];

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                  idex_bubble, exmem_en, memwb_en, memwb_bubble};

    always #5 clk = ~clk;

    pipe_ctrl #(
        .BR_SHADOW (BR_SHADOW),
        .MAX_DWAIT (MAX_DWAIT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hazard_n     (hazard_n),
        .br_taken_ex  (br_taken_ex),
        .imem_stall   (imem_stall),
        .dmem_stall   (dmem_stall),
        .halt_mem     (halt_mem),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_bubble  (idex_bubble),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .memwb_bubble (memwb_bubble),
        .halted       (halted),
        .dwait_err    (dwait_err),
        .state_o      (state_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_haz_cnt  (stall_haz_cnt),
        .stall_dmem_cnt (stall_dmem_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    // Drive one cycle of inputs at the falling edge and settle before sampling
    task automatic applyStimulus(input logic hn, input logic br, input logic im,
                                 input logic dm, input logic ht);
        @(negedge clk);
        hazard_n    = hn;
        br_taken_ex = br;
        imem_stall  = im;
        dmem_stall  = dm;
        halt_mem    = ht;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic setVec(input int idx, input logic hn, input logic br,
                          input logic im, input logic dm, input logic ht,
                          input logic [7:0] c, input logic [1:0] st);
        vecs[idx].hazard_n = hn;
        vecs[idx].br       = br;
        vecs[idx].imem     = im;
        vecs[idx].dmem     = dm;
        vecs[idx].halt     = ht;
        vecs[idx].ctl      = c;
        vecs[idx].st       = st;
    endtask

    // Pull reset low in the middle of a cycle and check it acts without a clock edge
    task automatic midCycleReset(input string name);
        @(negedge clk);
        hazard_n = 1'b1; br_taken_ex = 1'b0; imem_stall = 1'b0;
        dmem_stall = 1'b0; halt_mem = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput({name, " status"}, {12'h0, halted, dwait_err, state_o}, 16'h0000);
        checkOutput({name, " ctl"}, {8'h0, ctl}, {8'h0, C_NORM});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // inputs: hazard_n, br, imem, dmem, halt; expected ctl and state
        setVec( 0, 1, 0, 0, 0, 0, C_NORM,   2'd0);
        setVec( 1, 0, 0, 0, 0, 0, C_HAZ,    2'd0);
        setVec( 2, 0, 0, 0, 0, 0, C_HAZ,    2'd0);
        setVec( 3, 1, 0, 0, 0, 0, C_NORM,   2'd0);
        setVec( 4, 0, 0, 1, 0, 0, C_HAZ,    2'd0);
        setVec( 5, 1, 0, 1, 0, 0, C_IMEM,   2'd0);
        setVec( 6, 1, 1, 0, 0, 0, C_BRANCH, 2'd0);
        setVec( 7, 1, 0, 0, 0, 0, C_SHADOW, 2'd1);
        setVec( 8, 1, 0, 0, 0, 0, C_NORM,   2'd0);
        setVec( 9, 1, 1, 0, 1, 0, C_DMEM,   2'd0);
        setVec(10, 1, 1, 0, 1, 0, C_DMEM,   2'd2);
        setVec(11, 1, 1, 0, 1, 0, C_DMEM,   2'd2);
        setVec(12, 1, 1, 0, 0, 0, C_BRANCH, 2'd2);
        setVec(13, 1, 0, 0, 1, 0, C_DMEM,   2'd1);
        setVec(14, 1, 0, 0, 0, 0, C_SHADOW, 2'd2);
        setVec(15, 1, 0, 0, 0, 0, C_NORM,   2'd0);
        setVec(16, 0, 1, 0, 0, 0, C_BRANCH, 2'd0);
        setVec(17, 1, 1, 0, 0, 0, C_BRANCH, 2'd1);
        setVec(18, 0, 0, 0, 0, 0, C_SHADOW, 2'd1);
        setVec(19, 1, 0, 0, 1, 1, C_DMEM,   2'd2 - 2'd2);
        setVec(20, 1, 0, 0, 0, 0, C_NORM,   2'd2);
        setVec(21, 1, 0, 0, 0, 0, C_NORM,   2'd0);

        // Reset state
        #2;
        checkOutput("reset status", {12'h0, halted, dwait_err, state_o}, 16'h0000);
        checkOutput("reset ctl", {8'h0, ctl}, {8'h0, C_NORM});
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].hazard_n, vecs[i].br, vecs[i].imem,
                          vecs[i].dmem, vecs[i].halt);
            checkOutput($sformatf("vec%0d ctl", i), {8'h0, ctl}, {8'h0, vecs[i].ctl});
            checkOutput($sformatf("vec%0d status", i),
                        {12'h0, halted, dwait_err, state_o}, {14'h0, vecs[i].st});
        end

        // Data-memory stuck busy: timeout after the fourth stall cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 1, 0);
            checkOutput($sformatf("dwait%0d ctl", i), {8'h0, ctl}, {8'h0, C_DMEM});
            checkOutput($sformatf("dwait%0d status", i),
                        {12'h0, halted, dwait_err, state_o},
                        (i == 0) ? 16'h0000 : 16'h0002);
        end
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("timeout ctl", {8'h0, ctl}, {8'h0, C_OFF});
        checkOutput("timeout status", {12'h0, halted, dwait_err, state_o}, 16'h000F);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("timeout hold ctl", {8'h0, ctl}, {8'h0, C_OFF});
        checkOutput("timeout hold status", {12'h0, halted, dwait_err, state_o}, 16'h000F);
        midCycleReset("timeout reset");

        // HALT retiring from MEM
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("halt ctl", {8'h0, ctl}, {8'h0, C_HALTM});
        checkOutput("halt status", {12'h0, halted, dwait_err, state_o}, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("halted ctl", {8'h0, ctl}, {8'h0, C_OFF});
        checkOutput("halted status", {12'h0, halted, dwait_err, state_o}, 16'h000B);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("halted sticky ctl", {8'h0, ctl}, {8'h0, C_OFF});
        checkOutput("halted sticky status", {12'h0, halted, dwait_err, state_o}, 16'h000B);
        midCycleReset("halt reset");

`ifdef PIPE_CTRL_PERF_EN
        // Hazard counter saturates, flush counter sees a single imem flush
        midCycleReset("perf reset");
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("perf haz sat", {12'h0, stall_haz_cnt}, 16'd15);
        checkOutput("perf dmem zero", {12'h0, stall_dmem_cnt}, 16'd0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("perf flush one", {12'h0, flush_cnt}, 16'd1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("perf dmem one", {12'h0, stall_dmem_cnt}, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
